// File: rtl/signed_shift_add_multiplier.sv
// Multi-cycle signed multiplier: magnitudes are multiplied by an unsigned shift-add loop,
// then the sign is restored. Uses the same start/busy/done handshake as the restoring divider.
module signed_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      count;
    logic               sign;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     acc_sum;
    logic [2*WIDTH:0]   acc_q_shifted;
    logic [2*WIDTH-1:0] p_mag;
    logic [2*WIDTH-1:0] p_signed;

    // Magnitudes are kept as unsigned WIDTH bits so the most negative operand maps to 2^(WIDTH-1).
    always_comb begin
        abs_a         = A[WIDTH-1] ? (~A + 1'b1) : A;
        abs_b         = B[WIDTH-1] ? (~B + 1'b1) : B;
        acc_sum       = acc + {1'b0, m};
        acc_q_shifted = {acc, q} >> 1;
        p_mag         = {acc[WIDTH-1:0], q};
        p_signed      = sign ? (~p_mag + 1'b1) : p_mag;
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = start ? S_INIT : S_IDLE;
            S_INIT:  next_state = S_ADD;
            S_ADD:   next_state = S_SHIFT;
            S_SHIFT: next_state = (count == '0) ? S_FIX : S_ADD;
            S_FIX:   next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    m     <= abs_a;
                    q     <= abs_b;
                    acc   <= '0;
                    count <= COUNT_INIT;
                    sign  <= A[WIDTH-1] ^ B[WIDTH-1];
                end
                S_ADD: begin
                    if (q[0]) begin
                        acc <= acc_sum;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_q_shifted[2*WIDTH:WIDTH];
                    q   <= acc_q_shifted[WIDTH-1:0];
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                S_FIX: begin
                    product <= p_signed;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == S_INIT) || (state == S_ADD) || (state == S_SHIFT) || (state == S_FIX);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_signed_shift_add_multiplier.sv
// Directed bench for signed_shift_add_multiplier: products, latency, busy/done timing,
// ignored start requests, mid-operation reset and back-to-back operation.
module tb_signed_shift_add_multiplier;

    localparam int WIDTH     = 8;
    localparam int LAT       = 19;
    localparam int BUSY_LAST = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    signed_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    // Launches one operation from IDLE and observes 24 cycles; cycle 1 is the INIT cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int pulse1, input int pulse2, input bit scramble,
                          output int done_cycle, output int done_count, output int busy_bad,
                          output logic [15:0] prod_at_done);
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk); #1;
        start = 1'b0;
        done_cycle   = -1;
        done_count   = 0;
        busy_bad     = 0;
        prod_at_done = 16'hxxxx;
        for (int c = 1; c <= 24; c++) begin
            start = (c == pulse1) || (c == pulse2);
            if (scramble && c >= 2) begin
                A = ~a;
                B = a ^ b ^ 8'h5A;
            end
            if (done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle   = c;
                    prod_at_done = product;
                end
            end
            if (busy !== ((c >= 1) && (c <= BUSY_LAST))) busy_bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (product !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_product: got %h expected 0000", product);
        end
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_no_start: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int dc, dn, bb;
        logic [15:0] pd;
        run_op(8'd7, 8'd6, 0, 0, 1'b0, dc, dn, bb, pd);
        compared++;
        if (dc !== LAT) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d expected %0d", dc, LAT);
        end
        compared++;
        if (dn !== 1) begin
            mismatched++;
            $display("[TB] FAIL basic_done_width: got %0d expected 1", dn);
        end
        compared++;
        if (bb !== 0) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_window: got %0d bad cycles expected 0", bb);
        end
        compared++;
        if (pd !== 16'h002A) begin
            mismatched++;
            $display("[TB] FAIL basic_product_at_done: got %h expected 002A", pd);
        end
        compared++;
        if (product !== 16'h002A) begin
            mismatched++;
            $display("[TB] FAIL basic_product_held: got %h expected 002A", product);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  ta [12] = '{8'hFD, 8'h05, 8'h80, 8'h80, 8'h00, 8'h7F,
                                 8'hFF, 8'h7F, 8'h80, 8'h01, 8'h55, 8'hF9};
        logic [7:0]  tb [12] = '{8'h05, 8'hFD, 8'h80, 8'h01, 8'hFB, 8'h7F,
                                 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h33, 8'hF7};
        logic [15:0] te [12] = '{16'hFFF1, 16'hFFF1, 16'h4000, 16'hFF80, 16'h0000, 16'h3F01,
                                 16'h0001, 16'hC080, 16'hC080, 16'hFFFF, 16'h10EF, 16'h003F};
        int dc, dn, bb;
        logic [15:0] pd;
        for (int i = 0; i < 12; i++) begin
            run_op(ta[i], tb[i], 0, 0, 1'b0, dc, dn, bb, pd);
            compared++;
            if (pd !== te[i] || dc !== LAT) begin
                mismatched++;
                $display("[TB] FAIL vector_%0d (A=%h B=%h): got %h at cycle %0d expected %h at cycle %0d",
                         i, ta[i], tb[i], pd, dc, te[i], LAT);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dc, dn, bb;
        logic [15:0] pd;
        run_op(8'hF9, 8'h0B, 6, LAT, 1'b1, dc, dn, bb, pd);
        compared++;
        if (dn !== 1 || dc !== LAT) begin
            mismatched++;
            $display("[TB] FAIL ignore_done_pulses: got %0d pulses first at %0d expected 1 at %0d",
                     dn, dc, LAT);
        end
        compared++;
        if (pd !== 16'hFFB3) begin
            mismatched++;
            $display("[TB] FAIL ignore_product: got %h expected FFB3", pd);
        end
        compared++;
        if (bb !== 0 || product !== 16'hFFB3) begin
            mismatched++;
            $display("[TB] FAIL ignore_after: got busy_bad=%0d product=%h expected 0 FFB3", bb, product);
        end
    endtask

    task automatic test_midreset();
        int dc, dn, bb;
        logic [15:0] pd;
        run_op(8'd3, 8'd4, 0, 0, 1'b0, dc, dn, bb, pd);
        start = 1'b1;
        A = 8'h7F;
        B = 8'h7F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        compared++;
        if (busy !== 1'b1 || product !== 16'h000C) begin
            mismatched++;
            $display("[TB] FAIL midreset_pre: got busy=%b product=%h expected 1 000C", busy, product);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got busy=%b done=%b product=%h expected 0 0 0000",
                     busy, done, product);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_no_done: got busy=%b done=%b expected 0 0", busy, done);
        end
        run_op(8'hFA, 8'h09, 0, 0, 1'b0, dc, dn, bb, pd);
        compared++;
        if (pd !== 16'hFFCA || dc !== LAT || dn !== 1) begin
            mismatched++;
            $display("[TB] FAIL midreset_recover: got %h cycle %0d pulses %0d expected FFCA %0d 1",
                     pd, dc, dn, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        logic [15:0] p1 = 16'h0000;
        logic [15:0] p2 = 16'h0000;
        start = 1'b1;
        A = 8'd7;
        B = 8'd6;
        @(posedge clk); #1;
        for (int c = 1; c <= 45; c++) begin
            if (c == 20) begin
                A = 8'hFD;
                B = 8'h05;
            end
            if (c >= 21) start = 1'b0;
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    p1 = product;
                end else if (second < 0) begin
                    second = c;
                    p2 = product;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        compared++;
        if (first !== LAT || p1 !== 16'h002A) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got cycle %0d product %h expected %0d 002A", first, p1, LAT);
        end
        compared++;
        if (second !== 2 * LAT + 1 || p2 !== 16'hFFF1) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got cycle %0d product %h expected %0d FFF1",
                     second, p2, 2 * LAT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignored_start();
        test_midreset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
